// File: rtl/voice_scheduler.sv
// -----------------------------------------------------------------------------
// voice_scheduler
//
// Per-sample sequencer for the shared envelope generator, plus arbiter for the
// single shared multiplier.
//
// Sequencer: on each sample tick it walks voices 0..NUM_VOICES-1 through the
// envelope unit. Each voice gets a one-cycle start pulse. The scheduler then
// waits for env_ready_i, or gives up after TIMEOUT_CYCLES cycles.
//
// Arbiter: it grants the multiplier to the envelope path or the filter path.
// When both are waiting it alternates between them. It routes mult_ready_i back
// to the current owner only.
//
// The two halves run independently. A frame boundary does not reset the
// arbiter.
//
// Optional feature macro: VOICE_MASK_EN
//   Defined   : adds voice_en_i. Disabled voices are skipped with no start
//               pulse and no cycles spent.
//   Undefined : every voice is processed.
//
// Ports:
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   sample_tick_i     one-cycle pulse that starts a frame
//   status_clr_i      clears the sticky overrun/timeout flags
//   env_start_o       one-cycle start pulse to the envelope unit
//   env_voice_idx_o   voice index currently being sequenced
//   env_ready_i       envelope done for the current voice
//   voice_en_i        per-voice enable (VOICE_MASK_EN only)
//   mult_req_env_i    envelope multiply request pulse
//   mult_req_flt_i    filter multiply request pulse
//   mult_start_o      one-cycle start to the multiplier (grant cycle)
//   mult_sel_o        operand mux select, 0 = envelope, 1 = filter
//   mult_ready_i      multiplier result valid
//   env_mult_ready_o  mult_ready_i routed to the envelope owner
//   flt_mult_ready_o  mult_ready_i routed to the filter owner
//   busy_o            frame in progress
//   frame_done_o      one-cycle pulse after the last voice completes
//   overrun_o         sticky: a tick arrived while busy
//   timeout_o         sticky: a voice timed out
// -----------------------------------------------------------------------------
module voice_scheduler #(
    parameter int NUM_VOICES     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sample_tick_i,
    input  logic                  status_clr_i,
    output logic                  env_start_o,
    output logic [1:0]            env_voice_idx_o,
    input  logic                  env_ready_i,
`ifdef VOICE_MASK_EN
    input  logic [NUM_VOICES-1:0] voice_en_i,
`endif
    input  logic                  mult_req_env_i,
    input  logic                  mult_req_flt_i,
    output logic                  mult_start_o,
    output logic                  mult_sel_o,
    input  logic                  mult_ready_i,
    output logic                  env_mult_ready_o,
    output logic                  flt_mult_ready_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  overrun_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_START = 2'd1,
        SEQ_WAIT  = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_t;

    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // ---------------------------------------------------------------- state
    seq_state_t r_seq_state;
    logic [1:0] r_idx;
    logic [7:0] r_cnt;
    logic       r_env_start;
    logic       r_busy;
    logic       r_frame_done;
    logic       r_overrun;
    logic       r_timeout;

    arb_state_t r_arb_state;
    logic       r_pend_env;
    logic       r_pend_flt;
    logic       r_last_grant;   // 0 = envelope, 1 = filter
    logic       r_mult_sel;

    // ---------------------------------------------------------------- wires
    logic       w_first_valid;
    logic [1:0] w_first_idx;
    logic       w_next_valid;
    logic [1:0] w_next_idx;
    logic       w_timeout_hit;
    logic       w_advance;
    logic       w_grant_valid;
    logic       w_grant_sel;

    // Voice selection: first voice of a frame and the voice after r_idx
    always_comb begin
        w_first_valid = 1'b0;
        w_first_idx   = 2'd0;
        w_next_valid  = 1'b0;
        w_next_idx    = 2'd0;
`ifdef VOICE_MASK_EN
        // Walk downwards so the lowest qualifying index is the one that sticks.
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (voice_en_i[v]) begin
                w_first_valid = 1'b1;
                w_first_idx   = 2'(v);
            end else begin
                w_first_valid = w_first_valid;
            end
            if (voice_en_i[v] && (v > int'(r_idx))) begin
                w_next_valid = 1'b1;
                w_next_idx   = 2'(v);
            end else begin
                w_next_valid = w_next_valid;
            end
        end
`else
        w_first_valid = 1'b1;
        w_first_idx   = 2'd0;
        if (int'(r_idx) < (NUM_VOICES - 1)) begin
            w_next_valid = 1'b1;
            w_next_idx   = r_idx + 2'd1;
        end else begin
            w_next_valid = 1'b0;
            w_next_idx   = 2'd0;
        end
`endif
    end

    // Wait-state exits: a ready or an expired timeout both move to the next voice
    always_comb begin
        w_timeout_hit = (r_seq_state == SEQ_WAIT) && !env_ready_i &&
                        (r_cnt == 8'(TIMEOUT_CYCLES - 1));
        w_advance     = (r_seq_state == SEQ_WAIT) && (env_ready_i || w_timeout_hit);
    end

    // Envelope sequencer FSM with registered outputs and sticky status flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_seq_state  <= SEQ_IDLE;
            r_idx        <= 2'd0;
            r_cnt        <= 8'd0;
            r_env_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_env_start  <= 1'b0;
            r_frame_done <= 1'b0;

            // Set wins over a simultaneous clear. r_busy is also high in
            // SEQ_DONE, so a tick coinciding with frame_done_o counts.
            if (sample_tick_i && r_busy) begin
                r_overrun <= 1'b1;
            end else if (status_clr_i) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end

            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end else if (status_clr_i) begin
                r_timeout <= 1'b0;
            end else begin
                r_timeout <= r_timeout;
            end

            case (r_seq_state)
                SEQ_IDLE: begin
                    if (sample_tick_i) begin
                        r_idx  <= w_first_idx;
                        r_busy <= 1'b1;
                        if (w_first_valid) begin
                            r_seq_state <= SEQ_START;
                            r_env_start <= 1'b1;
                        end else begin
                            // No voice enabled: the frame ends immediately.
                            r_seq_state  <= SEQ_DONE;
                            r_frame_done <= 1'b1;
                        end
                    end else begin
                        r_seq_state <= SEQ_IDLE;
                    end
                end
                SEQ_START: begin
                    r_cnt       <= 8'd0;
                    r_seq_state <= SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    if (w_advance) begin
                        if (w_next_valid) begin
                            r_idx       <= w_next_idx;
                            r_seq_state <= SEQ_START;
                            r_env_start <= 1'b1;
                        end else begin
                            r_seq_state  <= SEQ_DONE;
                            r_frame_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                SEQ_DONE: begin
                    r_busy      <= 1'b0;
                    r_seq_state <= SEQ_IDLE;
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_seq_state <= SEQ_IDLE;
                end
            endcase
        end
    end

    // Grant decision: round-robin on contention, direct grant otherwise
    always_comb begin
        w_grant_valid = (r_arb_state == ARB_FREE) && (r_pend_env || r_pend_flt);
        if (r_pend_env && r_pend_flt) begin
            w_grant_sel = ~r_last_grant;
        end else if (r_pend_flt) begin
            w_grant_sel = 1'b1;
        end else begin
            w_grant_sel = 1'b0;
        end
    end

    // Multiplier arbiter FSM and pending-request latches
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_arb_state  <= ARB_FREE;
            r_pend_env   <= 1'b0;
            r_pend_flt   <= 1'b0;
            r_last_grant <= 1'b1;
            r_mult_sel   <= 1'b0;
        end else begin
            // Requests are only ever latched here. A request in a FREE cycle is
            // therefore granted on the following cycle. A new pulse overrides
            // the clear of the owner's own flag in the grant cycle.
            r_pend_env <= (r_pend_env & ~(w_grant_valid & ~w_grant_sel)) | mult_req_env_i;
            r_pend_flt <= (r_pend_flt & ~(w_grant_valid &  w_grant_sel)) | mult_req_flt_i;

            case (r_arb_state)
                ARB_FREE: begin
                    if (w_grant_valid) begin
                        r_mult_sel   <= w_grant_sel;
                        r_last_grant <= w_grant_sel;
                        r_arb_state  <= ARB_BUSY;
                    end else begin
                        r_arb_state <= ARB_FREE;
                    end
                end
                ARB_BUSY: begin
                    if (mult_ready_i) begin
                        r_arb_state <= ARB_FREE;
                    end else begin
                        r_arb_state <= ARB_BUSY;
                    end
                end
                default: begin
                    r_arb_state <= ARB_FREE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign env_start_o      = r_env_start;
    assign env_voice_idx_o  = r_idx;
    assign busy_o           = r_busy;
    assign frame_done_o     = r_frame_done;
    assign overrun_o        = r_overrun;
    assign timeout_o        = r_timeout;
    assign mult_sel_o       = r_mult_sel;
    // The start pulse marks the grant cycle and decodes registered state only.
    assign mult_start_o     = w_grant_valid;
    // The ready path is combinational. It reaches only the owner, and only
    // while the multiplier is owned.
    assign env_mult_ready_o = mult_ready_i && (r_arb_state == ARB_BUSY) && !r_mult_sel;
    assign flt_mult_ready_o = mult_ready_i && (r_arb_state == ARB_BUSY) &&  r_mult_sel;

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       sample_tick_i = 1'b0;
    logic       status_clr_i = 1'b0;
    logic       env_start_o;
    logic [1:0] env_voice_idx_o;
    logic       env_ready_i = 1'b0;
    logic       mult_req_env_i = 1'b0;
    logic       mult_req_flt_i = 1'b0;
    logic       mult_start_o;
    logic       mult_sel_o;
    logic       mult_ready_i = 1'b0;
    logic       env_mult_ready_o;
    logic       flt_mult_ready_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       overrun_o;
    logic       timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    voice_scheduler #(.NUM_VOICES(3), .TIMEOUT_CYCLES(255)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .sample_tick_i    (sample_tick_i),
        .status_clr_i     (status_clr_i),
        .env_start_o      (env_start_o),
        .env_voice_idx_o  (env_voice_idx_o),
        .env_ready_i      (env_ready_i),
        .mult_req_env_i   (mult_req_env_i),
        .mult_req_flt_i   (mult_req_flt_i),
        .mult_start_o     (mult_start_o),
        .mult_sel_o       (mult_sel_o),
        .mult_ready_i     (mult_ready_i),
        .env_mult_ready_o (env_mult_ready_o),
        .flt_mult_ready_o (flt_mult_ready_o),
        .busy_o           (busy_o),
        .frame_done_o     (frame_done_o),
        .overrun_o        (overrun_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one cycle. Outputs are then settled and inputs can be driven.
    task automatic nxt();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset state
        rst_i = 1'b1;
        nxt();
        nxt();
        chk("rst_env_start", 32'(env_start_o), 32'd0);
        chk("rst_idx", 32'(env_voice_idx_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_frame_done", 32'(frame_done_o), 32'd0);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_mult_start", 32'(mult_start_o), 32'd0);
        chk("rst_mult_sel", 32'(mult_sel_o), 32'd0);
        rst_i = 1'b0;
        nxt();

        // ---------------- nominal frame, ready 4 cycles after each start,
        // plus a second tick 4 cycles into the frame (overrun)
        sample_tick_i = 1'b1;
        nxt();
        sample_tick_i = 1'b0;
        for (int v = 0; v < 3; v++) begin
            chk("nom_start", 32'(env_start_o), 32'd1);
            chk("nom_start_idx", 32'(env_voice_idx_o), 32'(v));
            chk("nom_busy", 32'(busy_o), 32'd1);
            nxt();
            chk("nom_start_width", 32'(env_start_o), 32'd0);
            nxt();
            nxt();
            if (v == 0) begin
                chk("ovr_before", 32'(overrun_o), 32'd0);
                sample_tick_i = 1'b1;
            end
            nxt();
            sample_tick_i = 1'b0;
            if (v == 0) begin
                chk("ovr_set", 32'(overrun_o), 32'd1);
            end
            chk("nom_idx_held", 32'(env_voice_idx_o), 32'(v));
            chk("nom_no_start", 32'(env_start_o), 32'd0);
            env_ready_i = 1'b1;
            nxt();
            env_ready_i = 1'b0;
        end
        chk("nom_frame_done", 32'(frame_done_o), 32'd1);
        chk("nom_busy_done", 32'(busy_o), 32'd1);
        chk("nom_done_no_start", 32'(env_start_o), 32'd0);
        nxt();
        chk("nom_frame_done_width", 32'(frame_done_o), 32'd0);
        chk("nom_idle_busy", 32'(busy_o), 32'd0);
        chk("ovr_sticky", 32'(overrun_o), 32'd1);
        status_clr_i = 1'b1;
        nxt();
        status_clr_i = 1'b0;
        chk("ovr_cleared", 32'(overrun_o), 32'd0);

        // ---------------- timeout on voice 1
        sample_tick_i = 1'b1;
        nxt();
        sample_tick_i = 1'b0;
        chk("to_start0", 32'(env_start_o), 32'd1);
        nxt();
        env_ready_i = 1'b1;
        nxt();
        env_ready_i = 1'b0;
        chk("to_start1", 32'(env_start_o), 32'd1);
        chk("to_idx1", 32'(env_voice_idx_o), 32'd1);
        repeat (255) nxt();
        chk("to_not_yet", 32'(timeout_o), 32'd0);
        chk("to_no_early_start", 32'(env_start_o), 32'd0);
        nxt();
        chk("to_flag", 32'(timeout_o), 32'd1);
        chk("to_start2", 32'(env_start_o), 32'd1);
        chk("to_idx2", 32'(env_voice_idx_o), 32'd2);
        nxt();
        env_ready_i = 1'b1;
        nxt();
        env_ready_i = 1'b0;
        chk("to_frame_done", 32'(frame_done_o), 32'd1);
        // Tick coincident with frame_done_o counts as overrun and is ignored.
        sample_tick_i = 1'b1;
        nxt();
        sample_tick_i = 1'b0;
        chk("ovr_coincident", 32'(overrun_o), 32'd1);
        chk("ovr_coincident_ignored", 32'(busy_o), 32'd0);
        chk("ovr_coincident_no_start", 32'(env_start_o), 32'd0);
        chk("to_sticky", 32'(timeout_o), 32'd1);
        status_clr_i = 1'b1;
        nxt();
        status_clr_i = 1'b0;
        chk("to_cleared", 32'(timeout_o), 32'd0);
        chk("ovr_cleared2", 32'(overrun_o), 32'd0);

        // ---------------- arbitration contention (last_grant = flt since reset)
        mult_req_env_i = 1'b1;
        mult_req_flt_i = 1'b1;
        chk("arb_no_same_cycle_grant", 32'(mult_start_o), 32'd0);
        nxt();
        mult_req_env_i = 1'b0;
        mult_req_flt_i = 1'b0;
        chk("arb_grant1_start", 32'(mult_start_o), 32'd1);
        nxt();
        chk("arb_grant1_width", 32'(mult_start_o), 32'd0);
        chk("arb_grant1_sel_env", 32'(mult_sel_o), 32'd0);
        mult_ready_i = 1'b1;
        #1;
        chk("arb_env_ready", 32'(env_mult_ready_o), 32'd1);
        chk("arb_flt_ready_gated", 32'(flt_mult_ready_o), 32'd0);
        nxt();
        mult_ready_i = 1'b0;
        chk("arb_grant2_start", 32'(mult_start_o), 32'd1);
        nxt();
        chk("arb_grant2_sel_flt", 32'(mult_sel_o), 32'd1);
        chk("arb_grant2_width", 32'(mult_start_o), 32'd0);

        // ---------------- duplicate env request while flt owns
        mult_req_env_i = 1'b1;
        nxt();
        mult_req_env_i = 1'b0;
        chk("busy_req_latched_no_start", 32'(mult_start_o), 32'd0);
        mult_req_env_i = 1'b1;
        nxt();
        mult_req_env_i = 1'b0;
        chk("busy_sel_held", 32'(mult_sel_o), 32'd1);
        mult_ready_i = 1'b1;
        #1;
        chk("busy_flt_ready", 32'(flt_mult_ready_o), 32'd1);
        chk("busy_env_ready_gated", 32'(env_mult_ready_o), 32'd0);
        nxt();
        mult_ready_i = 1'b0;
        chk("busy_grant_after_ready", 32'(mult_start_o), 32'd1);
        nxt();
        chk("busy_grant_sel_env", 32'(mult_sel_o), 32'd0);
        mult_ready_i = 1'b1;
        nxt();
        mult_ready_i = 1'b0;
        chk("dup_single_grant", 32'(mult_start_o), 32'd0);
        nxt();
        chk("dup_single_grant2", 32'(mult_start_o), 32'd0);
        // Ready while FREE is not routed anywhere.
        mult_ready_i = 1'b1;
        #1;
        chk("free_ready_env", 32'(env_mult_ready_o), 32'd0);
        chk("free_ready_flt", 32'(flt_mult_ready_o), 32'd0);
        nxt();
        mult_ready_i = 1'b0;

        // ---------------- reset mid-WAIT (voice 1) and mid-BUSY with env pending
        sample_tick_i = 1'b1;
        mult_req_flt_i = 1'b1;
        nxt();
        sample_tick_i = 1'b0;
        mult_req_flt_i = 1'b0;
        chk("mr_start0", 32'(env_start_o), 32'd1);
        chk("mr_grant_flt", 32'(mult_start_o), 32'd1);
        nxt();
        mult_req_env_i = 1'b1;
        env_ready_i = 1'b1;
        nxt();
        mult_req_env_i = 1'b0;
        env_ready_i = 1'b0;
        chk("mr_start1_idx", 32'(env_voice_idx_o), 32'd1);
        nxt();
        rst_i = 1'b1;
        nxt();
        rst_i = 1'b0;
        chk("mr_busy", 32'(busy_o), 32'd0);
        chk("mr_idx", 32'(env_voice_idx_o), 32'd0);
        chk("mr_env_start", 32'(env_start_o), 32'd0);
        chk("mr_mult_start", 32'(mult_start_o), 32'd0);
        chk("mr_mult_sel", 32'(mult_sel_o), 32'd0);
        mult_ready_i = 1'b1;
        #1;
        chk("mr_flt_ready", 32'(flt_mult_ready_o), 32'd0);
        chk("mr_env_ready", 32'(env_mult_ready_o), 32'd0);
        mult_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nxt();
            chk("mr_no_stray_env_start", 32'(env_start_o), 32'd0);
            chk("mr_no_stray_mult_start", 32'(mult_start_o), 32'd0);
        end
        sample_tick_i = 1'b1;
        nxt();
        sample_tick_i = 1'b0;
        chk("mr_restart", 32'(env_start_o), 32'd1);
        chk("mr_restart_idx", 32'(env_voice_idx_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
